seg_scan_decoder: RTL and testbench

Reader for the multiplexed seven-segment bus that the ALU display path drives: it watches the anode, cathode and DP lines and recovers the hex value shown on each digit. It lets simulation benches and on-chip self-check logic read displayed results as numbers instead of raw segment patterns. All lines are active-low, as on the board.

---
 rtl/seg_scan_decoder.sv | 141 ++++++++++++++
 tb/tb_seg_scan_decoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Recovers the hex value shown on each digit of an active-low multiplexed
// seven-segment bus, with frame accounting and sticky error flags.
module seg_scan_decoder #(
   parameter int N_DIGITS      = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  CLK100MHZ,
   input  logic                  CPU_RESETN,
   input  logic [N_DIGITS-1:0]   AN,
   input  logic [6:0]            segment,
   input  logic                  DP,
   input  logic                  err_clr,
   output logic [4*N_DIGITS-1:0] digit_val,
   output logic [N_DIGITS-1:0]   digit_valid,
   output logic [N_DIGITS-1:0]   digit_dp,
   output logic                  frame_done,
   output logic [15:0]           frame_count,
   output logic                  err_anode,
   output logic                  err_pattern
);

   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

   // {valid, nibble} for an active-low glyph; blank and illegal both give 0
   function automatic logic [4:0] decode(input logic [6:0] seg);
      case (seg)
         7'h40: decode = 5'h10;
         7'h79: decode = 5'h11;
         7'h24: decode = 5'h12;
         7'h30: decode = 5'h13;
         7'h19: decode = 5'h14;
         7'h12: decode = 5'h15;
         7'h02: decode = 5'h16;
         7'h78: decode = 5'h17;
         7'h00: decode = 5'h18;
         7'h10: decode = 5'h19;
         7'h08: decode = 5'h1A;
         7'h03: decode = 5'h1B;
         7'h46: decode = 5'h1C;
         7'h21: decode = 5'h1D;
         7'h06: decode = 5'h1E;
         7'h0E: decode = 5'h1F;
         default: decode = 5'h00;
      endcase
   endfunction

   logic                s_vld;
   logic [N_DIGITS-1:0] s_an;
   logic [N_DIGITS-1:0] prev_an;
   logic [6:0]          s_seg;
   logic                s_dp;
   logic [7:0]          cnt;
   logic [N_DIGITS-1:0] mask;

   logic [7:0]          zcnt;
   logic [IW-1:0]       idx;
   logic                onehot;
   logic                multi;
   logic [7:0]          cnt_nxt;
   logic                capture;
   logic [4:0]          dec;
   logic                blank;
   logic [N_DIGITS-1:0] mask_set;

   // s_vld keeps the all-zero post-reset sample from reading as multi-hot
   always_comb begin
      zcnt = '0;
      idx  = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (!s_an[i]) begin
            zcnt = zcnt + 8'd1;
            idx  = IW'(i);
         end
      end
      onehot = s_vld && (zcnt == 8'd1);
      multi  = s_vld && (zcnt > 8'd1);
      if (!onehot)
         cnt_nxt = '0;
      else if (s_an != prev_an)
         cnt_nxt = 8'd1;
      else if (cnt < STABLE)
         cnt_nxt = cnt + 8'd1;
      else
         cnt_nxt = cnt;
      capture = onehot && (cnt_nxt == STABLE) && (cnt != STABLE);
      dec      = decode(s_seg);
      blank    = (s_seg == 7'h7F);
      mask_set = mask;
      mask_set[idx] = 1'b1;
   end

   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         s_vld       <= 1'b0;
         s_an        <= '0;
         prev_an     <= '0;
         s_seg       <= '0;
         s_dp        <= 1'b0;
         cnt         <= '0;
         mask        <= '0;
         digit_val   <= '0;
         digit_valid <= '0;
         digit_dp    <= '0;
         frame_done  <= 1'b0;
         frame_count <= '0;
         err_anode   <= 1'b0;
         err_pattern <= 1'b0;
      end else begin
         s_vld      <= 1'b1;
         s_an       <= AN;
         s_seg      <= segment;
         s_dp       <= DP;
         prev_an    <= s_an;
         cnt        <= cnt_nxt;
         frame_done <= 1'b0;
         if (capture) begin
            digit_val[4*idx +: 4] <= dec[3:0];
            digit_valid[idx]      <= dec[4];
            digit_dp[idx]         <= ~s_dp;
            if (&mask_set) begin
               mask        <= '0;
               frame_done  <= 1'b1;
               frame_count <= frame_count + 16'd1;
            end else begin
               mask <= mask_set;
            end
         end
         // a fresh error outranks a simultaneous clear
         if (multi)
            err_anode <= 1'b1;
         else if (err_clr)
            err_anode <= 1'b0;
         if (capture && !dec[4] && !blank)
            err_pattern <= 1'b1;
         else if (err_clr)
            err_pattern <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (N_DIGITS=8, STABLE_CYCLES=4) with
// hand-computed expectations.
module tb_seg_scan_decoder;

   logic        clk = 1'b0;
   logic        rstn;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        err_clr;
   logic [31:0] digit_val;
   logic [7:0]  digit_valid;
   logic [7:0]  digit_dp;
   logic        frame_done;
   logic [15:0] frame_count;
   logic        err_anode;
   logic        err_pattern;

   int n_chk  = 0;
   int n_fail = 0;
   int fd_cnt = 0;
   int fd_base;

   logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg_scan_decoder #(.N_DIGITS(8), .STABLE_CYCLES(4)) dut (
      .CLK100MHZ  (clk),
      .CPU_RESETN (rstn),
      .AN         (an),
      .segment    (seg),
      .DP         (dp),
      .err_clr    (err_clr),
      .digit_val  (digit_val),
      .digit_valid(digit_valid),
      .digit_dp   (digit_dp),
      .frame_done (frame_done),
      .frame_count(frame_count),
      .err_anode  (err_anode),
      .err_pattern(err_pattern)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_done) fd_cnt++;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      an = 8'hFF; seg = 7'h7F; dp = 1'b1; err_clr = 1'b0;
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
   endtask

   // drive one digit for 'cycles' clocks; capture lands on the 5th edge
   task automatic show(input int d, input logic [6:0] s, input logic p, input int cycles = 6);
      an  = ~(8'h01 << d);
      seg = s;
      dp  = p;
      tick(cycles);
   endtask

   initial begin
      an = 8'hFF; seg = 7'h7F; dp = 1'b1; err_clr = 1'b0; rstn = 1'b0;
      tick(2);
      rstn = 1'b1;
      chk("rst_val",   digit_val, 32'h0);
      chk("rst_valid", {24'h0, digit_valid}, 32'h0);
      chk("rst_dp",    {24'h0, digit_dp}, 32'h0);
      chk("rst_cnt",   {16'h0, frame_count}, 32'h0);
      chk("rst_errs",  {30'h0, err_anode, err_pattern}, 32'h0);
      tick(3);
      chk("idle_no_err", {31'h0, err_anode}, 32'h0);

      // full scan 0..7
      fd_base = fd_cnt;
      for (int i = 0; i < 8; i++) show(i, glyph[i], 1'b1);
      an = 8'hFF; tick(3);
      chk("scan_val",   digit_val, 32'h76543210);
      chk("scan_valid", {24'h0, digit_valid}, 32'h0000_00FF);
      chk("scan_dp",    {24'h0, digit_dp}, 32'h0);
      chk("scan_fd",    fd_cnt - fd_base, 32'd1);
      chk("scan_cnt",   {16'h0, frame_count}, 32'd1);

      // short dwell on digit 0, then long dwell on digit 1 with a late glyph change
      do_reset();
      tick(2);
      fd_base = fd_cnt;
      show(0, glyph[5], 1'b1, 3);
      show(1, glyph[9], 1'b1, 6);
      seg = glyph[3];
      tick(4);
      an = 8'hFF; tick(2);
      chk("glitch_val",   digit_val, 32'h0000_0090);
      chk("glitch_valid", {24'h0, digit_valid}, 32'h0000_0002);
      for (int i = 2; i < 8; i++) show(i, glyph[i], 1'b1);
      show(1, glyph[1], 1'b1);
      an = 8'hFF; tick(2);
      chk("glitch_nofd", fd_cnt - fd_base, 32'd0);
      show(0, glyph[0], 1'b1);
      an = 8'hFF; tick(2);
      chk("glitch_fd",  fd_cnt - fd_base, 32'd1);
      chk("glitch_cnt", {16'h0, frame_count}, 32'd1);
      chk("glitch_all", digit_val, 32'h76543210);

      // multi-hot anode error
      an = 8'hFC; tick();
      an = 8'hFF; tick(2);
      chk("anode_err", {31'h0, err_anode}, 32'd1);
      show(0, glyph[0], 1'b1);
      an = 8'hFF; tick();
      chk("anode_sticky", {31'h0, err_anode}, 32'd1);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("anode_clr", {31'h0, err_anode}, 32'd0);
      an = 8'hFC; tick();
      an = 8'hFF; err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("anode_err_wins", {31'h0, err_anode}, 32'd1);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("anode_clr2", {31'h0, err_anode}, 32'd0);

      // blank, illegal pattern, decimal point
      show(3, 7'h7F, 1'b1);
      chk("blank_valid", {31'h0, digit_valid[3]}, 32'd0);
      chk("blank_val",   {28'h0, digit_val[15:12]}, 32'd0);
      chk("blank_noerr", {31'h0, err_pattern}, 32'd0);
      show(4, 7'h55, 1'b1);
      chk("bad_valid", {31'h0, digit_valid[4]}, 32'd0);
      chk("bad_err",   {31'h0, err_pattern}, 32'd1);
      show(5, glyph[10], 1'b0);
      chk("dp_lit",   {31'h0, digit_dp[5]}, 32'd1);
      chk("dp_val",   {28'h0, digit_val[23:20]}, 32'hA);
      chk("dp_other", {31'h0, digit_dp[4]}, 32'd0);

      // frame counter wrap
      do_reset();
      tick();
      force dut.frame_count = 16'hFFFF;
      #1;
      release dut.frame_count;
      fd_base = fd_cnt;
      for (int i = 0; i < 8; i++) show(i, glyph[15 - i], 1'b1);
      an = 8'hFF; tick(3);
      chk("wrap_cnt", {16'h0, frame_count}, 32'h0);
      chk("wrap_fd",  fd_cnt - fd_base, 32'd1);
      chk("wrap_val", digit_val, 32'h89ABCDEF);

      // reset in the middle of a frame
      for (int i = 0; i < 5; i++) show(i, glyph[i], 1'b0);
      an = 8'hFF;
      rstn = 1'b0; tick(); rstn = 1'b1;
      chk("mid_rst_val",   digit_val, 32'h0);
      chk("mid_rst_valid", {24'h0, digit_valid}, 32'h0);
      chk("mid_rst_dp",    {24'h0, digit_dp}, 32'h0);
      chk("mid_rst_cnt",   {16'h0, frame_count}, 32'h0);
      tick(2);
      fd_base = fd_cnt;
      for (int i = 5; i < 8; i++) show(i, glyph[i], 1'b1);
      an = 8'hFF; tick(2);
      chk("mid_rst_nofd", fd_cnt - fd_base, 32'd0);
      for (int i = 0; i < 5; i++) show(i, glyph[i], 1'b1);
      an = 8'hFF; tick(2);
      chk("mid_rst_fd",  fd_cnt - fd_base, 32'd1);
      chk("mid_rst_cnt1", {16'h0, frame_count}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
